// File: rtl/input_buffer.sv
// input_buffer
// -----------------------------------------------------------------------------
// Input-group assembly stage between the input memory bus and the first hidden
// layer. One n-bit word is sampled per cycle while in_we is high. After sx
// words the complete group moves into a stable parallel register (x_vec) and
// x_valid rises. The next group can shift in while the consumer still holds
// the previous one.
//
// Optional feature (compile-time macro):
//   INBUF_CLAMP_EN - when defined, each sampled word is saturated to
//                    [-(1<<f), +(1<<f)] before it enters the shift stage.
//                    When undefined, words pass through bit-exact.
//
// Parameters:
//   sx  - words per group (>= 1)
//   n   - word width in bits
//   f   - fraction bits (only used by the clamp)
//   gw  - width of the completed-group counter
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous reset, active low
//   flush   - synchronous clear of the partial group, x_valid and ovr
//   in_we   - sample din on this edge
//   din     - signed input word
//   x_take  - consumer accepts the current x_vec
//   x_vec   - assembled group, k-th sampled word at [k*n +: n]
//   x_valid - x_vec holds an unconsumed group
//   busy    - a partial group is in progress
//   ovr     - sticky overrun flag (group replaced before it was taken)
//   grp_cnt - completed groups modulo 2^gw
// -----------------------------------------------------------------------------
module input_buffer #(
    parameter int sx = 2,
    parameter int n  = 16,
    parameter int f  = 12,
    parameter int gw = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_we,
    input  logic [n-1:0]    din,
    input  logic            x_take,
    output logic [sx*n-1:0] x_vec,
    output logic            x_valid,
    output logic            busy,
    output logic            ovr,
    output logic [gw-1:0]   grp_cnt
);

    // The shift stage holds sx-1 words; for sx == 1 a single dummy word keeps
    // the declarations legal, it never reaches the output.
    localparam int SW = (sx > 1) ? (sx - 1) * n : n;
    localparam int CW = (sx > 1) ? $clog2(sx) : 1;
    localparam logic [CW-1:0] LAST = CW'(sx - 1);

`ifdef INBUF_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    localparam logic signed [n-1:0] SAT_HI = n'(1 << f);
    localparam logic signed [n-1:0] SAT_LO = -SAT_HI;

    function automatic logic [n-1:0] saturate(input logic [n-1:0] w);
        logic signed [n-1:0] s;
        s = signed'(w);
        if (s > SAT_HI) begin
            return SAT_HI;
        end else if (s < SAT_LO) begin
            return SAT_LO;
        end
        return w;
    endfunction

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [sx*n-1:0] x_vec_q, x_vec_d;
    logic            x_valid_q, x_valid_d;
    logic            ovr_q, ovr_d;
    logic            busy_q, busy_d;
    logic [gw-1:0]   grp_cnt_q, grp_cnt_d;

    logic [n-1:0]    word_in;
    logic [SW-1:0]   stage_shift;
    logic [sx*n-1:0] full_grp;
    logic            complete;

    assign word_in  = CLAMP_ON ? saturate(din) : din;
    assign complete = in_we && (cnt_q == LAST);

    // Shift toward slot 0 with the new word on top, so the first sampled word
    // of a group always ends up in the lowest slot of x_vec.
    generate
        if (sx > 2) begin : g_shift_wide
            assign stage_shift = {word_in, stage_q[SW-1:n]};
        end else begin : g_shift_single
            assign stage_shift = word_in;
        end

        if (sx > 1) begin : g_full_multi
            assign full_grp = {word_in, stage_q};
        end else begin : g_full_single
            assign full_grp = word_in;
        end
    endgenerate

    always_comb begin
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        x_vec_d   = x_vec_q;
        x_valid_d = x_valid_q;
        ovr_d     = ovr_q;
        grp_cnt_d = grp_cnt_q;

        if (flush) begin
            // flush wins over in_we and x_take; x_vec and grp_cnt are kept
            cnt_d     = '0;
            stage_d   = '0;
            x_valid_d = 1'b0;
            ovr_d     = 1'b0;
        end else begin
            if (in_we) begin
                stage_d = stage_shift;
                cnt_d   = complete ? '0 : cnt_q + CW'(1);
            end
            if (complete) begin
                // a new group replacing one that nobody took is an overrun
                x_vec_d   = full_grp;
                x_valid_d = 1'b1;
                grp_cnt_d = grp_cnt_q + gw'(1);
                if (x_valid_q && !x_take) begin
                    ovr_d = 1'b1;
                end
            end else if (x_take) begin
                x_valid_d = 1'b0;
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            stage_q   <= '0;
            x_vec_q   <= '0;
            x_valid_q <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
            grp_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            x_vec_q   <= x_vec_d;
            x_valid_q <= x_valid_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
            grp_cnt_q <= grp_cnt_d;
        end
    end

    assign x_vec   = x_vec_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign ovr     = ovr_q;
    assign grp_cnt = grp_cnt_q;

endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer
// -----------------------------------------------------------------------------
// Scoreboard bench for input_buffer with sx=3, n=16, f=12, gw=4.
// A driver applies directed and random stimulus, advances a queue-based
// reference model after every edge and pushes the expected state. A separate
// monitor pops those expectations on the falling edge and compares them with
// the DUT; completed groups are additionally checked whenever grp_cnt moves.
// -----------------------------------------------------------------------------
module tb_input_buffer;

    localparam int SX = 3;
    localparam int N  = 16;
    localparam int F  = 12;
    localparam int GW = 4;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_we;
    logic [N-1:0]    din;
    logic            x_take;
    logic [SX*N-1:0] x_vec;
    logic            x_valid;
    logic            busy;
    logic            ovr;
    logic [GW-1:0]   grp_cnt;

    input_buffer #(.sx(SX), .n(N), .f(F), .gw(GW)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_we   (in_we),
        .din     (din),
        .x_take  (x_take),
        .x_vec   (x_vec),
        .x_valid (x_valid),
        .busy    (busy),
        .ovr     (ovr),
        .grp_cnt (grp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SX*N-1:0] x_vec;
        logic            x_valid;
        logic            busy;
        logic            ovr;
        logic [GW-1:0]   grp;
    } status_t;

    typedef struct {
        logic [SX*N-1:0] x_vec;
        logic [GW-1:0]   grp;
    } group_t;

    status_t stat_q[$];
    group_t  grp_q[$];

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    // reference model state
    int          part_q[$];
    logic [N-1:0] m_xvec[SX];
    bit          m_valid;
    bit          m_ovr;
    int          m_grp;
    logic        prev_rst;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] clamp_word(input logic [N-1:0] d);
        int v;
        v = int'($signed(d));
`ifdef INBUF_CLAMP_EN
        if (v > (1 << F)) v = (1 << F);
        if (v < -(1 << F)) v = -(1 << F);
`endif
        return v[N-1:0];
    endfunction

    function automatic logic [SX*N-1:0] pack_model();
        logic [SX*N-1:0] v;
        for (int k = 0; k < SX; k++) v[k*N +: N] = m_xvec[k];
        return v;
    endfunction

    // Applies the behavioural rules for one rising edge.
    task automatic model_step(input logic r, input logic fl, input logic we,
                              input logic [N-1:0] d, input logic tk);
        bit     got_grp;
        group_t g;
        status_t s;
        got_grp = 1'b0;
        if (!r) begin
            part_q.delete();
            for (int k = 0; k < SX; k++) m_xvec[k] = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_grp   = 0;
        end else if (fl) begin
            part_q.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (we) begin
                part_q.push_back(int'(clamp_word(d)));
                if (part_q.size() == SX) begin
                    for (int k = 0; k < SX; k++) m_xvec[k] = part_q[k][N-1:0];
                    part_q.delete();
                    got_grp = 1'b1;
                end
            end
            if (got_grp) begin
                if (m_valid && !tk) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_grp   = (m_grp + 1) % (1 << GW);
                g.x_vec = pack_model();
                g.grp   = m_grp[GW-1:0];
                grp_q.push_back(g);
            end else if (tk) begin
                m_valid = 1'b0;
            end
        end
        s.x_vec   = pack_model();
        s.x_valid = m_valid;
        s.busy    = (part_q.size() != 0);
        s.ovr     = m_ovr;
        s.grp     = m_grp[GW-1:0];
        stat_q.push_back(s);
    endtask

    // One clock cycle: inputs change just after the falling edge, the model
    // advances just after the rising edge.
    task automatic apply_stimulus(input logic r, input logic fl, input logic we,
                                  input logic [N-1:0] d, input logic tk);
        @(negedge clk);
        #1;
        prev_rst = rst;
        rst    = r;
        flush  = fl;
        in_we  = we;
        din    = d;
        x_take = tk;
        if (!r && prev_rst) begin
            #1;
            check_output("async_reset", 64'({x_vec, x_valid, busy, ovr, grp_cnt}), 64'd0);
        end
        @(posedge clk);
        #1;
        model_step(r, fl, we, d, tk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic write_word(input logic [N-1:0] d, input logic tk);
        apply_stimulus(1'b1, 1'b0, 1'b1, d, tk);
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: compares every observed cycle and every completed group.
    initial begin : monitor
        status_t     s;
        group_t      g;
        logic [GW-1:0] last_grp;
        last_grp = '0;
        while (!done) begin
            @(negedge clk);
            if (stat_q.size() != 0) begin
                s = stat_q.pop_front();
                check_output("x_vec", 64'(x_vec), 64'(s.x_vec));
                check_output("x_valid", 64'(x_valid), 64'(s.x_valid));
                check_output("busy", 64'(busy), 64'(s.busy));
                check_output("ovr", 64'(ovr), 64'(s.ovr));
                check_output("grp_cnt", 64'(grp_cnt), 64'(s.grp));
            end
            if (rst !== 1'b1) begin
                last_grp = grp_cnt;
            end else if (grp_cnt !== last_grp) begin
                if (grp_q.size() == 0) begin
                    check_output("unexpected_group", 64'(grp_cnt), 64'(last_grp));
                end else begin
                    g = grp_q.pop_front();
                    check_output("group_vec", 64'(x_vec), 64'(g.x_vec));
                    check_output("group_cnt", 64'(grp_cnt), 64'(g.grp));
                end
                last_grp = grp_cnt;
            end
        end
    end

    initial begin : driver
        rst      = 1'b0;
        flush    = 1'b0;
        in_we    = 1'b0;
        din      = '0;
        x_take   = 1'b0;
        prev_rst = 1'b0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_grp    = 0;
        for (int k = 0; k < SX; k++) m_xvec[k] = '0;

        do_reset();
        idle(1);

        // basic assembly, then consume it
        write_word(16'h0100, 1'b0);
        write_word(16'h0200, 1'b0);
        write_word(16'h0300, 1'b0);
        idle(2);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // gap tolerance
        write_word(16'h0001, 1'b0);
        write_word(16'h0002, 1'b0);
        idle(5);
        write_word(16'h0003, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // overrun: two back-to-back groups without take
        for (int i = 1; i <= 6; i++) write_word(16'(i), 1'b0);
        idle(2);
        apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        // same, but take on the second completion edge
        for (int i = 1; i <= 5; i++) write_word(16'(i), 1'b0);
        write_word(16'h0006, 1'b1);
        idle(2);

        // flush mid-group, flush beating in_we, then clean assembly
        write_word(16'h00AA, 1'b0);
        write_word(16'h00BB, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'h00CC, 1'b1);
        write_word(16'h0007, 1'b0);
        write_word(16'h0008, 1'b0);
        write_word(16'h0009, 1'b0);
        idle(1);

        // reset mid-group, then clean assembly
        write_word(16'h0011, 1'b0);
        write_word(16'h0022, 1'b0);
        do_reset();
        write_word(16'h0007, 1'b0);
        write_word(16'h0008, 1'b0);
        write_word(16'h0009, 1'b1);
        idle(1);

        // clamp boundary words
        write_word(16'h3000, 1'b1);
        write_word(16'hC000, 1'b1);
        write_word(16'h0800, 1'b1);
        write_word(16'h1000, 1'b1);
        write_word(16'hF000, 1'b1);
        write_word(16'h1001, 1'b1);
        write_word(16'hEFFF, 1'b1);
        write_word(16'h7FFF, 1'b1);
        write_word(16'h8000, 1'b1);
        idle(1);

        // counter wrap: 17 groups from reset with gw=4
        do_reset();
        for (int i = 0; i < 17 * SX; i++) write_word(16'($urandom), 1'b1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic r, fl, we, tk;
            logic [N-1:0] d;
            r  = ($urandom_range(0, 199) != 0);
            fl = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 9) < 6);
            tk = ($urandom_range(0, 9) < 3);
            d  = ($urandom_range(0, 3) == 0) ? 16'(16'h1000 + $urandom_range(0, 2) - 1)
                                             : 16'($urandom);
            if ($urandom_range(0, 7) == 0) d = -d;
            apply_stimulus(r, fl, we, d, tk);
        end
        idle(3);

        @(negedge clk);
        #1;
        done = 1'b1;
        check_output("status_queue_drained", 64'(stat_q.size()), 64'd0);
        check_output("group_queue_drained", 64'(grp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // hard stop in case anything above ever stalls
    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
